// File: rtl/izhikevich_state_update.sv
// ============================================================================
// izhikevich_state_update : v/w state registers, threshold/reset and spike count
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module izhikevich_state_update #(
    parameter int N  = 20,
    parameter int Q  = 10,
    parameter int CW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic signed [N-1:0] v_init,
    input  logic signed [N-1:0] w_init,
    input  logic                step_valid,
    output logic                step_ready,
    input  logic signed [N-1:0] dv,
    input  logic signed [N-1:0] dw,
    input  logic signed [N-1:0] v_th,
    input  logic signed [N-1:0] c,
    input  logic signed [N-1:0] d,
    output logic signed [N-1:0] v,
    output logic signed [N-1:0] w,
    output logic                spike,
    output logic                out_valid,
    output logic [CW-1:0]       spike_count
);

    localparam logic signed [N-1:0] c_max = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] c_min = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0]       c_cnt_max = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTEG = 2'd1,
        FIRE  = 2'd2
    } state_t;

    state_t              r_state;
    logic signed [N-1:0] r_v;
    logic signed [N-1:0] r_w;
    logic signed [N-1:0] r_dv;
    logic signed [N-1:0] r_dw;
    logic signed [N-1:0] r_vn;
    logic signed [N-1:0] r_wn;
    logic                r_spike;
    logic                r_out_valid;
    logic [CW-1:0]       r_count;

    // Q only fixes how the words are interpreted; the datapath itself is scale-free.
    if (Q >= N) begin : g_q_out_of_range
    end

    function automatic logic signed [N-1:0] sat_add(
        input logic signed [N-1:0] a,
        input logic signed [N-1:0] b
    );
        logic signed [N:0] s;
        s = {a[N-1], a} + {b[N-1], b};
        if (s[N] != s[N-1])
            sat_add = s[N] ? c_min : c_max;
        else
            sat_add = s[N-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_v         <= '0;
            r_w         <= '0;
            r_dv        <= '0;
            r_dw        <= '0;
            r_vn        <= '0;
            r_wn        <= '0;
            r_spike     <= 1'b0;
            r_out_valid <= 1'b0;
            r_count     <= '0;
        end else begin
            r_spike     <= 1'b0;
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_v     <= v_init;
                        r_w     <= w_init;
                        r_count <= '0;
                    end else if (step_valid) begin
                        r_dv    <= dv;
                        r_dw    <= dw;
                        r_state <= INTEG;
                    end
                end
                INTEG: begin
                    r_vn    <= sat_add(r_v, r_dv);
                    r_wn    <= sat_add(r_w, r_dw);
                    r_state <= FIRE;
                end
                FIRE: begin
                    r_out_valid <= 1'b1;
                    if (r_vn >= v_th) begin
                        r_v     <= c;
                        r_w     <= sat_add(r_wn, d);
                        r_spike <= 1'b1;
                        if (r_count != c_cnt_max)
                            r_count <= r_count + 1'b1;
                    end else begin
                        r_v <= r_vn;
                        r_w <= r_wn;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign step_ready  = (r_state == IDLE);
    assign v           = r_v;
    assign w           = r_w;
    assign spike       = r_spike;
    assign out_valid   = r_out_valid;
    assign spike_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_izhikevich_state_update.sv
// ============================================================================
// tb_izhikevich_state_update : directed + randomized checks against a model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_izhikevich_state_update;

    localparam int     N     = 20;
    localparam int     CW    = 4;
    localparam longint VMAX  = 524287;
    localparam longint VMIN  = -524288;
    localparam longint CMAX  = 15;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                load;
    logic signed [N-1:0] v_init, w_init, dv, dw, v_th, c, d;
    logic                step_valid;
    logic                step_ready;
    logic signed [N-1:0] v, w;
    logic                spike, out_valid;
    logic [CW-1:0]       spike_count;

    int checks = 0;
    int errors = 0;

    longint mv, mw, mcnt;

    izhikevich_state_update #(.N(N), .Q(10), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .v_init(v_init), .w_init(w_init),
        .step_valid(step_valid), .step_ready(step_ready), .dv(dv), .dw(dw),
        .v_th(v_th), .c(c), .d(d), .v(v), .w(w), .spike(spike),
        .out_valid(out_valid), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint clamp(input longint x);
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return x;
    endfunction

    function automatic longint rnd();
        return longint'($urandom_range(0, 1048575)) - 524288;
    endfunction

    task automatic do_load(input longint lv, input longint lw, input bit collide);
        load = 1'b1; v_init = N'(lv); w_init = N'(lw);
        step_valid = collide; dv = N'(rnd()); dw = N'(rnd());
        @(posedge clk); @(negedge clk);
        load = 1'b0; step_valid = 1'b0;
        mv = lv; mw = lw; mcnt = 0;
        chk("load_v", v, mv);
        chk("load_w", w, mw);
        chk("load_count", spike_count, mcnt);
        chk("load_ready", step_ready, 1);
        chk("load_no_valid", out_valid, 0);
    endtask

    // One step; poke drives load/step_valid with junk while the step is in flight.
    task automatic do_step(input longint sdv, input longint sdw, input longint svth,
                           input longint sc, input longint sd, input bit poke);
        longint vn, wn, ev, ew, ecnt;
        bit     esp;
        vn = clamp(mv + sdv);
        wn = clamp(mw + sdw);
        ecnt = mcnt;
        if (vn >= svth) begin
            ev = sc; ew = clamp(wn + sd); esp = 1'b1;
            if (ecnt < CMAX) ecnt++;
        end else begin
            ev = vn; ew = wn; esp = 1'b0;
        end
        chk("ready_idle", step_ready, 1);
        step_valid = 1'b1; dv = N'(sdv); dw = N'(sdw);
        v_th = N'(rnd()); c = N'(rnd()); d = N'(rnd());
        @(posedge clk); @(negedge clk);
        step_valid = poke; load = poke;
        v_init = N'(rnd()); w_init = N'(rnd()); dv = N'(rnd()); dw = N'(rnd());
        v_th = N'(svth); c = N'(sc); d = N'(sd);
        chk("integ_ready", step_ready, 0);
        chk("integ_valid", out_valid, 0);
        chk("integ_spike", spike, 0);
        chk("integ_v_hold", v, mv);
        chk("integ_w_hold", w, mw);
        @(negedge clk);
        chk("fire_ready", step_ready, 0);
        chk("fire_valid", out_valid, 0);
        chk("fire_v_hold", v, mv);
        @(negedge clk);
        step_valid = 1'b0; load = 1'b0;
        chk("out_valid", out_valid, 1);
        chk("spike", spike, esp);
        chk("v", v, ev);
        chk("w", w, ew);
        chk("spike_count", spike_count, ecnt);
        mv = ev; mw = ew; mcnt = ecnt;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; step_valid = 1'b0;
        v_init = '0; w_init = '0; dv = '0; dw = '0; v_th = '0; c = '0; d = '0;
        mv = 0; mw = 0; mcnt = 0;
        #1;
        chk("rst_v", v, 0);
        chk("rst_w", w, 0);
        chk("rst_ready", step_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_spike", spike, 0);
        chk("rst_count", spike_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // first accept on the first edge after release
        do_step(1000, -2000, 30720, 0, 0, 0);

        do_load(-66560, 0, 0);
        do_step(1024, 512, 30720, 0, 0, 0);

        do_load(30208, 0, 0);
        do_step(1024, 512, 30720, -66560, 8192, 1);

        do_load(0, 524000, 0);
        do_step(0, 2048, VMAX, 0, 0, 0);
        do_load(0, -524188, 0);
        do_step(0, -1024, VMAX, 0, 0, 0);

        // load beats a simultaneous step request
        do_load(12345, -6789, 1);
        repeat (3) begin
            @(negedge clk);
            chk("collide_no_valid", out_valid, 0);
            chk("collide_v", v, 12345);
        end

        for (int i = 0; i < 30; i++)
            do_step(rnd() / 8, rnd() / 8, rnd(), rnd(), rnd() / 4, i[0]);

        // reset during INTEG
        step_valid = 1'b1; dv = 20'sd100; dw = 20'sd100;
        @(posedge clk); @(negedge clk);
        step_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_v", v, 0);
        chk("midrst_w", w, 0);
        chk("midrst_ready", step_ready, 1);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count", spike_count, 0);
        mv = 0; mw = 0; mcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_valid", out_valid, 0);
            chk("midrst_no_spike", spike, 0);
            chk("midrst_ready_after", step_ready, 1);
        end
        do_step(-500, 700, 100, 0, 0, 0);

        // spike counter saturation, then cleared by load
        do_load(0, 0, 0);
        repeat (19) do_step(0, 0, VMIN, 0, 0, 0);
        chk("count_saturated", spike_count, CMAX);
        do_load(5, 5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
